// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage RV32 core: load-use stalls, EX redirect squash,
// data-memory wait freeze with watchdog. Optional counters: PIPELINE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_DIST = 1,
  parameter int MEM_TIMEOUT   = 255,
  parameter int WAIT_W        = 8,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic [4:0]        mem_rd,
  input  logic              mem_mem_read,
  input  logic              ex_redirect,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              ex_mem_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mem_wb_flush,
  output logic              pc_redirect,
  output logic              mem_timeout_err,
  output logic [CNT_W-1:0]  perf_stall_cycles,
  output logic [CNT_W-1:0]  perf_flushes,
  output logic [CNT_W-1:0]  perf_load_use,
  output logic [1:0]        dbg_state,
  output logic [WAIT_W-1:0] dbg_wait_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam bit              DIST2       = (LOAD_USE_DIST == 2);
  localparam bit              WATCHDOG_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_nxt;
  logic              mem_hold;
  logic              rs1_hit, rs2_hit, load_use_hit;

  // x0 is hardwired zero, so a write to it can never create a dependency.
  assign rs1_hit = id_uses_rs1 && (id_rs1 != 5'd0) &&
                   ((ex_mem_read && (id_rs1 == ex_rd)) ||
                    (DIST2 && mem_mem_read && (id_rs1 == mem_rd)));
  assign rs2_hit = id_uses_rs2 && (id_rs2 != 5'd0) &&
                   ((ex_mem_read && (id_rs2 == ex_rd)) ||
                    (DIST2 && mem_mem_read && (id_rs2 == mem_rd)));
  assign load_use_hit = rs1_hit || rs2_hit;

  // Combinational so the first waiting cycle already freezes the pipe.
  assign mem_hold = ((state == RUN) && dmem_req && !dmem_ready) ||
                    (state == MEM_WAIT) || (state == ERROR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state           <= state_nxt;
      wait_cnt        <= wait_nxt;
      mem_timeout_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = mem_timeout_err;
    case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (WATCHDOG_EN && (wait_cnt == TIMEOUT_CNT)) begin
          state_nxt = ERROR;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Priority: memory hold, then EX redirect (squashes ID), then load-use.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    pc_redirect  = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
        pc_redirect = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_hit) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

`ifdef PIPELINE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, lu_cnt;
  logic             load_use_taken;

  assign load_use_taken = !rst && !mem_hold && !ex_redirect && load_use_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      lu_cnt    <= '0;
    end else begin
      if (pc_stall)       stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_redirect)    flush_cnt <= flush_cnt + CNT_W'(1);
      if (load_use_taken) lu_cnt    <= lu_cnt + CNT_W'(1);
    end
  end

  assign perf_stall_cycles = stall_cnt;
  assign perf_flushes      = flush_cnt;
  assign perf_load_use     = lu_cnt;
`else
  assign perf_stall_cycles = '0;
  assign perf_flushes      = '0;
  assign perf_load_use     = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table vectors plus multi-cycle memory-wait, timeout
// and reset sequences. dut uses LOAD_USE_DIST=1/MEM_TIMEOUT=4, dut_b uses LOAD_USE_DIST=2.
module tb_pipeline_hazard_ctrl;

  // Output vector bit order:
  // [8]pc_stall [7]if_id_stall [6]id_ex_stall [5]ex_mem_stall
  // [4]if_id_flush [3]id_ex_flush [2]mem_wb_flush [1]pc_redirect [0]mem_timeout_err
  localparam logic [8:0] O_NONE = 9'b000000000;
  localparam logic [8:0] O_LU   = 9'b110001000;
  localparam logic [8:0] O_RD   = 9'b000011010;
  localparam logic [8:0] O_MH   = 9'b111100100;
  localparam logic [8:0] O_ER   = 9'b111100101;
  localparam logic [8:0] O_EONL = 9'b000000001;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_MW  = 2'd1;
  localparam logic [1:0] ST_ERR = 2'd2;
`ifdef PIPELINE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] exrd;
    logic       exmr;
    logic [4:0] memrd;
    logic       memmr;
    logic       redir;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic [8:0] o;
    logic [1:0] st;
    logic       chk_wait;
    logic [7:0] wcnt;
    logic       chk2;
    logic       stall2;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, mem_mem_read;
  logic       ex_redirect, dmem_req, dmem_ready;

  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect, mem_timeout_err;
  logic [31:0] perf_stall_cycles, perf_flushes, perf_load_use;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_wait_cnt;

  logic        b_pc_stall, b_if_id_stall, b_id_ex_stall, b_ex_mem_stall;
  logic        b_if_id_flush, b_id_ex_flush, b_mem_wb_flush, b_pc_redirect, b_err;
  logic [31:0] b_perf_stall, b_perf_flush, b_perf_lu;
  logic [1:0]  b_dbg_state;
  logic [7:0]  b_dbg_wait;

  pipeline_hazard_ctrl #(.LOAD_USE_DIST(1), .MEM_TIMEOUT(4), .WAIT_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .pc_redirect(pc_redirect), .mem_timeout_err(mem_timeout_err),
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
    .perf_load_use(perf_load_use), .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  pipeline_hazard_ctrl #(.LOAD_USE_DIST(2), .MEM_TIMEOUT(255), .WAIT_W(8), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .id_ex_stall(b_id_ex_stall),
    .ex_mem_stall(b_ex_mem_stall), .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .mem_wb_flush(b_mem_wb_flush), .pc_redirect(b_pc_redirect), .mem_timeout_err(b_err),
    .perf_stall_cycles(b_perf_stall), .perf_flushes(b_perf_flush),
    .perf_load_use(b_perf_lu), .dbg_state(b_dbg_state), .dbg_wait_cnt(b_dbg_wait)
  );

  logic [8:0] act_o;
  assign act_o = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect, mem_timeout_err};

  // scoreboard
  logic [$bits(exp_t)-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int step_no = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
  logic [31:0] m_lu    = 32'd0;

  function automatic in_t mk(input logic r, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] exrd, input logic exmr,
                             input logic [4:0] memrd, input logic memmr,
                             input logic redir, input logic req, input logic rdy);
    mk = in_t'{r, rs1, u1, rs2, u2, exrd, exmr, memrd, memmr, redir, req, rdy};
  endfunction

  function automatic exp_t mke(input logic [8:0] o, input logic [1:0] st, input logic cw,
                               input logic [7:0] w, input logic c2, input logic s2);
    mke = exp_t'{o, st, cw, w, c2, s2};
  endfunction

  task automatic check_bit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s step%0d got %0h want %0h", name, step_no, got, want);
  endtask

  // driver: apply one cycle of inputs, push expectation, compare on the falling edge
  task automatic step(input in_t i, input exp_t e);
    exp_t got_e;
    @(posedge clk);
    #1;
    rst = i.rst; id_rs1 = i.rs1; id_uses_rs1 = i.u1; id_rs2 = i.rs2; id_uses_rs2 = i.u2;
    ex_rd = i.exrd; ex_mem_read = i.exmr; mem_rd = i.memrd; mem_mem_read = i.memmr;
    ex_redirect = i.redir; dmem_req = i.req; dmem_ready = i.rdy;
    exp_q.push_back(e);
    @(negedge clk);
    got_e = exp_t'(exp_q.pop_front());
    check_bit("outputs", {23'd0, act_o}, {23'd0, got_e.o});
    check_bit("state", {30'd0, dbg_state}, {30'd0, got_e.st});
    if (got_e.chk_wait) check_bit("wait_cnt", {24'd0, dbg_wait_cnt}, {24'd0, got_e.wcnt});
    if (got_e.chk2) check_bit("dist2_pc_stall", {31'd0, b_pc_stall}, {31'd0, got_e.stall2});
    if (i.rst) begin
      m_stall = 32'd0; m_flush = 32'd0; m_lu = 32'd0;
    end else begin
      m_stall = m_stall + {31'd0, got_e.o[8]};
      m_flush = m_flush + {31'd0, got_e.o[1]};
      m_lu    = m_lu + ((got_e.o == O_LU) ? 32'd1 : 32'd0);
    end
    step_no++;
  endtask

  task automatic check_perf();
    check_bit("perf_stall_cycles", perf_stall_cycles, PERF ? m_stall : 32'd0);
    check_bit("perf_flushes", perf_flushes, PERF ? m_flush : 32'd0);
    check_bit("perf_load_use", perf_load_use, PERF ? m_lu : 32'd0);
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = vec_t'{mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0)};
    tbl[1]  = vec_t'{mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0)};
    tbl[2]  = vec_t'{mk(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                     mke(O_LU, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b1)};
    tbl[3]  = vec_t'{mk(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b1)};
    tbl[4]  = vec_t'{mk(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0)};
    tbl[5]  = vec_t'{mk(1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0)};
    tbl[6]  = vec_t'{mk(1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                     mke(O_LU, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b1)};
    tbl[7]  = vec_t'{mk(1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b1)};
    tbl[8]  = vec_t'{mk(1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0)};
    tbl[9]  = vec_t'{mk(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0),
                     mke(O_RD, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0)};
    tbl[10] = vec_t'{mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0)};
    tbl[11] = vec_t'{mk(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
                     mke(O_MH, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b1)};
    tbl[12] = vec_t'{mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1),
                     mke(O_MH, ST_MW, 1'b1, 8'd1, 1'b1, 1'b1)};
    tbl[13] = vec_t'{mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0)};
    tbl[14] = vec_t'{mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0),
                     mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0)};
    tbl[15] = vec_t'{mk(1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                     mke(O_LU, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b1)};

    rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; mem_rd = 5'd0; mem_mem_read = 1'b0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 16; k++) step(tbl[k].i, tbl[k].e);
    check_perf();

    // random RUN-state hazard mix on a small register set to force collisions
    for (int k = 0; k < 24; k++) begin
      in_t  ri;
      logic h1, h2, m1, m2;
      ri = mk(1'b0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 1'b0, 1'b0);
      h1 = ri.u1 && (ri.rs1 != 5'd0) && ri.exmr && (ri.rs1 == ri.exrd);
      h2 = ri.u2 && (ri.rs2 != 5'd0) && ri.exmr && (ri.rs2 == ri.exrd);
      m1 = ri.u1 && (ri.rs1 != 5'd0) && ri.memmr && (ri.rs1 == ri.memrd);
      m2 = ri.u2 && (ri.rs2 != 5'd0) && ri.memmr && (ri.rs2 == ri.memrd);
      step(ri, mke(ri.redir ? O_RD : ((h1 || h2) ? O_LU : O_NONE), ST_RUN, 1'b1, 8'd0,
                   1'b1, !ri.redir && (h1 || h2 || m1 || m2)));
    end

    // memory wait outranks a redirect held for the whole wait
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0),
         mke(O_MH, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b1));
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0),
         mke(O_MH, ST_MW, 1'b1, 8'd1, 1'b1, 1'b1));
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0),
         mke(O_MH, ST_MW, 1'b1, 8'd2, 1'b1, 1'b1));
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1),
         mke(O_MH, ST_MW, 1'b1, 8'd3, 1'b1, 1'b1));
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0),
         mke(O_RD, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0));
    check_perf();

    // watchdog: 4 MEM_WAIT cycles then sticky ERROR until reset
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
         mke(O_MH, ST_RUN, 1'b1, 8'd0, 1'b0, 1'b0));
    for (int w = 1; w <= 4; w++)
      step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
           mke(O_MH, ST_MW, 1'b1, 8'(w), 1'b0, 1'b0));
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
         mke(O_ER, ST_ERR, 1'b0, 8'd0, 1'b0, 1'b0));
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1),
         mke(O_ER, ST_ERR, 1'b0, 8'd0, 1'b0, 1'b0));
    step(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1),
         mke(O_EONL, ST_ERR, 1'b0, 8'd0, 1'b0, 1'b0));
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
         mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0));

    // reset in the middle of a wait
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
         mke(O_MH, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b1));
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
         mke(O_MH, ST_MW, 1'b1, 8'd1, 1'b1, 1'b1));
    step(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
         mke(O_NONE, ST_MW, 1'b1, 8'd2, 1'b1, 1'b0));
    step(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
         mke(O_NONE, ST_RUN, 1'b1, 8'd0, 1'b1, 1'b0));
    check_perf();

    // final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
